// File: rtl/tmr_fault_monitor_pkg.sv
// rtl/tmr_fault_monitor_pkg.sv - shared error codes and FSM states for the TMR fault monitor
package tmr_fault_monitor_pkg;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_A    = 2'd1;
    localparam logic [1:0] ERR_B    = 2'd2;
    localparam logic [1:0] ERR_C    = 2'd3;

    typedef enum logic [1:0] {
        MON  = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/tmr_sat_counter.sv
// rtl/tmr_sat_counter.sv - saturating counter with clear, restart-at-one and increment
module tmr_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    // clear beats restart beats increment; increment stops at MAX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (start) begin
            count <= WIDTH'(1);
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/tmr_fault_monitor.sv
// rtl/tmr_fault_monitor.sv - TMR voter fault monitor with resync handshake; optional TMR_ERR_STATS_EN error counters
module tmr_fault_monitor
    import tmr_fault_monitor_pkg::*;
#(
    parameter int WIDTH   = 20,
    parameter int THRESH  = 4,
    parameter int HOLDOFF = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_error,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             resync_req,
    output logic [1:0]       resync_sel,
    output logic [WIDTH-1:0] resync_data,
    input  logic             resync_ack,
    output logic             busy,
    output logic             fatal
`ifdef TMR_ERR_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [15:0]      err_cnt_a,
    output logic [15:0]      err_cnt_b,
    output logic [15:0]      err_cnt_c
`endif
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    fsm_state_t          state;
    fsm_state_t          state_next;
    logic                set_fatal;
    logic [1:0]          cons_id;
    logic [3:0]          cons_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [7:0]          hold_cnt;
    logic                trk_err;
    logic                trk_same;
    logic                trigger;
    logic                trk_clr;
    logic                trk_start;
    logic                trk_inc;

    // the tracker only listens in MON; HOLD pins the run length at zero
    assign trk_err   = (state == MON) && in_valid && (in_error != ERR_NONE);
    assign trk_same  = (in_error == cons_id);
    assign trigger   = trk_err && trk_same && (cons_cnt == 4'(THRESH - 1));
    assign trk_clr   = (state == HOLD) || trigger ||
                       ((state == MON) && in_valid && (in_error == ERR_NONE));
    assign trk_start = trk_err && !trk_same;
    assign trk_inc   = trk_err && trk_same;

    tmr_sat_counter #(.WIDTH(4), .MAX(THRESH)) u_cons_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (trk_clr),
        .start (trk_start),
        .inc   (trk_inc),
        .count (cons_cnt)
    );

    assign resync_req = (state == REQ);
    assign busy       = (state != MON);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MON;
        end else begin
            state <= state_next;
        end
    end

    // next state; an ack in the timeout cycle still wins
    always_comb begin
        state_next = state;
        set_fatal  = 1'b0;
        case (state)
            MON: begin
                if (trigger) state_next = REQ;
            end
            REQ: begin
                if (resync_ack) begin
                    state_next = HOLD;
                end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                    state_next = MON;
                    set_fatal  = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt == 8'd1) state_next = MON;
            end
            default: state_next = MON;
        endcase
    end

    // pass-through, resync payload capture, wait/hold timers, sticky fatal, run id
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            resync_sel  <= ERR_NONE;
            resync_data <= '0;
            wait_cnt    <= '0;
            hold_cnt    <= '0;
            fatal       <= 1'b0;
            cons_id     <= ERR_NONE;
        end else begin
            out_valid <= in_valid;
            if (in_valid) out_data <= in_data;
            if (trigger) begin
                resync_sel  <= in_error;
                resync_data <= in_data;
            end
            if (state == MON) begin
                wait_cnt <= '0;
            end else if (state == REQ) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if ((state == REQ) && resync_ack) begin
                hold_cnt <= 8'(HOLDOFF);
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
            if (set_fatal) fatal <= 1'b1;
            if (trk_start) cons_id <= in_error;
        end
    end

`ifdef TMR_ERR_STATS_EN
    tmr_sat_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_cnt_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stats_clr),
        .start (1'b0),
        .inc   (in_valid && (in_error == ERR_A)),
        .count (err_cnt_a)
    );

    tmr_sat_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_cnt_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stats_clr),
        .start (1'b0),
        .inc   (in_valid && (in_error == ERR_B)),
        .count (err_cnt_b)
    );

    tmr_sat_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_cnt_c (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stats_clr),
        .start (1'b0),
        .inc   (in_valid && (in_error == ERR_C)),
        .count (err_cnt_c)
    );
`endif

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb/tb_tmr_fault_monitor.sv - self-checking bench for tmr_fault_monitor (covers TMR_ERR_STATS_EN when defined)
module tb_tmr_fault_monitor;

    localparam int THRESH  = 4;
    localparam int HOLDOFF = 8;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [19:0] in_data = '0;
    logic [1:0]  in_error = '0;
    logic        resync_ack = 1'b0;
    logic        out_valid;
    logic [19:0] out_data;
    logic        resync_req;
    logic [1:0]  resync_sel;
    logic [19:0] resync_data;
    logic        busy;
    logic        fatal;
`ifdef TMR_ERR_STATS_EN
    logic        stats_clr = 1'b0;
    logic [15:0] err_cnt_a;
    logic [15:0] err_cnt_b;
    logic [15:0] err_cnt_c;
`endif

    int checks = 0;
    int passes = 0;

    tmr_fault_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_error    (in_error),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .resync_req  (resync_req),
        .resync_sel  (resync_sel),
        .resync_data (resync_data),
        .resync_ack  (resync_ack),
        .busy        (busy),
        .fatal       (fatal)
`ifdef TMR_ERR_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .err_cnt_a   (err_cnt_a),
        .err_cnt_b   (err_cnt_b),
        .err_cnt_c   (err_cnt_c)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // behavioural model: run of identical error codes, plus a mode 0=watching 1=waiting for ack 2=settling
    int          m_mode, m_run_id, m_run_len, m_waited, m_settle;
    logic        m_fatal, m_ov;
    logic [1:0]  m_sel;
    logic [19:0] m_od, m_rdata;
    int          m_stat[4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_run_id = 0; m_run_len = 0; m_waited = 0; m_settle = 0;
            m_fatal = 0; m_ov = 0; m_sel = 0; m_od = 0; m_rdata = 0;
            for (int k = 0; k < 4; k++) m_stat[k] = 0;
        end else begin
            m_ov = in_valid;
            if (in_valid) m_od = in_data;
`ifdef TMR_ERR_STATS_EN
            for (int k = 1; k < 4; k++) begin
                if (stats_clr) m_stat[k] = 0;
                else if (in_valid && in_error == k && m_stat[k] < 65535) m_stat[k] = m_stat[k] + 1;
            end
`endif
            if (m_mode == 0) begin
                if (in_valid) begin
                    if (in_error == 0) m_run_len = 0;
                    else if (in_error == m_run_id) m_run_len = m_run_len + 1;
                    else begin
                        m_run_id = in_error;
                        m_run_len = 1;
                    end
                    if (m_run_len >= THRESH) begin
                        m_mode = 1; m_sel = in_error; m_rdata = in_data;
                        m_run_len = 0; m_waited = 0;
                    end
                end
            end else if (m_mode == 1) begin
                m_waited = m_waited + 1;
                if (resync_ack) begin
                    m_mode = 2; m_settle = HOLDOFF;
                end else if (m_waited >= TIMEOUT) begin
                    m_fatal = 1; m_mode = 0;
                end
            end else begin
                m_run_len = 0;
                m_settle = m_settle - 1;
                if (m_settle == 0) m_mode = 0;
            end
        end
    end

    // compare every output against the model on each falling edge out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            check("m_out_valid", 32'(out_valid), 32'(m_ov));
            check("m_out_data", 32'(out_data), 32'(m_od));
            check("m_resync_req", 32'(resync_req), 32'(m_mode == 1));
            check("m_busy", 32'(busy), 32'(m_mode != 0));
            check("m_fatal", 32'(fatal), 32'(m_fatal));
            if (m_mode == 1) begin
                check("m_resync_sel", 32'(resync_sel), 32'(m_sel));
                check("m_resync_data", 32'(resync_data), 32'(m_rdata));
            end
`ifdef TMR_ERR_STATS_EN
            check("m_err_cnt_a", 32'(err_cnt_a), 32'(m_stat[1]));
            check("m_err_cnt_b", 32'(err_cnt_b), 32'(m_stat[2]));
            check("m_err_cnt_c", 32'(err_cnt_c), 32'(m_stat[3]));
`endif
        end
    end

    task automatic step(input logic v, input logic [19:0] d, input logic [1:0] e, input logic a);
        in_valid = v; in_data = d; in_error = e; resync_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 20'h0, 2'd0, 1'b0);
    endtask

    logic        rv, ra;
    logic [1:0]  re;
    logic [19:0] rd;
    int          fault_id, ack_pct, r;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(resync_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fatal", 32'(fatal), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;

        // clean samples pass through
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 20'h12345, 2'd0, 1'b0);
            check("pass_data", 32'(out_data), 32'h12345);
            check("pass_req", 32'(resync_req), 32'd0);
            check("pass_busy", 32'(busy), 32'd0);
        end

        // four B errors -> request, ack on third request cycle, 8 cycles busy
        for (int i = 0; i < 4; i++) step(1'b1, 20'hABCDE, 2'd2, 1'b0);
        check("b_req", 32'(resync_req), 32'd1);
        check("b_sel", 32'(resync_sel), 32'd2);
        check("b_data", 32'(resync_data), 32'hABCDE);
        step(1'b1, 20'h0, 2'd0, 1'b0);
        step(1'b1, 20'h0, 2'd0, 1'b0);
        check("b_req_held", 32'(resync_req), 32'd1);
        step(1'b1, 20'h0, 2'd0, 1'b1);
        check("b_req_drop", 32'(resync_req), 32'd0);
        for (int i = 0; i < HOLDOFF; i++) begin
            check("b_hold_busy", 32'(busy), 32'd1);
            step(1'b1, 20'h0, 2'd3, 1'b1);
        end
        check("b_hold_end", 32'(busy), 32'd0);

        // broken run: 2,2,2,3,2,2,2
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 20'h00111, (i == 3) ? 2'd3 : 2'd2, 1'b0);
            check("broken_no_req", 32'(resync_req), 32'd0);
        end
        idle(1);

        // gap does not break a run
        step(1'b1, 20'h00A01, 2'd1, 1'b0);
        step(1'b1, 20'h00A02, 2'd1, 1'b0);
        step(1'b0, 20'h00A03, 2'd3, 1'b0);
        step(1'b1, 20'h00A04, 2'd1, 1'b0);
        check("gap_no_req_yet", 32'(resync_req), 32'd0);
        step(1'b1, 20'h00A05, 2'd1, 1'b0);
        check("gap_req", 32'(resync_req), 32'd1);
        check("gap_sel", 32'(resync_sel), 32'd1);
        check("gap_data", 32'(resync_data), 32'h00A05);
        step(1'b1, 20'h0, 2'd0, 1'b1);
        idle(HOLDOFF);

        // timeout -> fatal, then a second run still requests
        for (int i = 0; i < 4; i++) step(1'b1, 20'h00C0C, 2'd3, 1'b0);
        check("to_req", 32'(resync_req), 32'd1);
        idle(TIMEOUT - 1);
        check("to_req_last", 32'(resync_req), 32'd1);
        check("to_fatal_before", 32'(fatal), 32'd0);
        idle(1);
        check("to_fatal", 32'(fatal), 32'd1);
        check("to_req_off", 32'(resync_req), 32'd0);
        check("to_busy_off", 32'(busy), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 20'h00D0D, 2'd1, 1'b0);
        check("to2_req", 32'(resync_req), 32'd1);
        check("to2_sel", 32'(resync_sel), 32'd1);
        check("to2_fatal", 32'(fatal), 32'd1);

        // asynchronous reset while requesting
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req", 32'(resync_req), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_fatal", 32'(fatal), 32'd0);
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_sel", 32'(resync_sel), 32'd0);
        check("ar_data", 32'(resync_data), 32'd0);
        rst_n = 1'b1;

`ifdef TMR_ERR_STATS_EN
        for (int i = 0; i < 5; i++) step(1'b1, 20'h00E0E, 2'd3, 1'b0);
        check("st_cnt_c5", 32'(err_cnt_c), 32'd5);
        stats_clr = 1'b1;
        step(1'b1, 20'h00E0E, 2'd3, 1'b0);
        stats_clr = 1'b0;
        check("st_cnt_c_clr", 32'(err_cnt_c), 32'd0);
        step(1'b1, 20'h0, 2'd0, 1'b1);
        idle(HOLDOFF);
`endif

        // randomized traffic in segments with differing ack likelihood
        fault_id = 1;
        for (int seg = 0; seg < 12; seg++) begin
            ack_pct = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 30 : 4);
            for (int c = 0; c < 250; c++) begin
                if ($urandom_range(0, 39) == 0) fault_id = $urandom_range(1, 3);
                rv = ($urandom_range(0, 99) < 85);
                r = $urandom_range(0, 99);
                if (r < 55) re = 2'(fault_id);
                else if (r < 85) re = 2'd0;
                else re = 2'($urandom_range(1, 3));
                ra = ($urandom_range(0, 99) < ack_pct);
                rd = 20'($urandom);
`ifdef TMR_ERR_STATS_EN
                stats_clr = ($urandom_range(0, 99) == 0);
`endif
                step(rv, rd, re, ra);
            end
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/tmr_fault_monitor.md
Name: tmr_fault_monitor

Overview:
- Sits directly downstream of the 20-bit TMR voter; consumes its voted word and 2-bit error code (0 none, 1 A wrong, 2 B wrong, 3 C wrong).
- Registers the voted word onward and tracks consecutive miscompares per replica.
- When one replica disagrees THRESH samples in a row, issues a req/ack resync request carrying the last good voted word, so the faulty replica can be reloaded.
- Holds off for a settle window after each resync.

Parameters:
- WIDTH, 20, width of voted data word.
- THRESH, 4, consecutive error samples from one replica that declare it faulty (2..15).
- HOLDOFF, 8, cycles after resync_ack during which error codes are ignored (1..255).
- TIMEOUT, 64, cycles resync_req may wait for resync_ack before a fatal flag is set (1..1023).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  voter outputs valid this cycle.
- in_data  input  WIDTH  voted word V from the voter.
- in_error  input  2  voter error code.
- out_valid  output  1  registered copy of in_valid.
- out_data  output  WIDTH  registered copy of in_data.
- resync_req  output  1  resync request; held high until acknowledged.
- resync_sel  output  2  replica to reload (1=A, 2=B, 3=C); stable while resync_req is high.
- resync_data  output  WIDTH  voted word to load; stable while resync_req is high.
- resync_ack  input  1  resync accepted; counts only while resync_req is high.
- busy  output  1  high in REQ or HOLD states.
- fatal  output  1  sticky; ack timeout occurred. Cleared only by reset.

Behaviour:
- Reset (async, rst_n low): every output is 0; the state machine enters MON; all counters are 0.
- Pass-through: out_valid and out_data equal in_valid and in_data delayed one cycle, in every state. out_data holds its value when in_valid is 0.
- Consecutive tracking applies only in MON with in_valid=1:
  - in_error=0: cons_cnt←0.
  - in_error==cons_id: cons_cnt←cons_cnt+1, saturating at THRESH.
  - Any other nonzero code: cons_id←in_error, cons_cnt←1.
- in_valid=0 leaves the tracker unchanged. Gaps do not break a run.
- FSM states: MON, REQ, HOLD.
- MON→REQ: on the sample where cons_cnt would become THRESH.
  - That same edge latches resync_sel←in_error and resync_data←in_data.
  - resync_req rises on that same edge, so it is visible one cycle after the triggering sample.
  - cons_cnt←0.
- REQ:
  - resync_req=1 and busy=1.
  - resync_sel and resync_data are frozen.
  - The wait counter increments each cycle.
  - resync_ack=1 → HOLD: resync_req drops on the next edge; the hold counter loads HOLDOFF.
  - If the wait counter reaches TIMEOUT without ack → fatal←1 and the block returns to MON with resync_req=0.
  - Ack on the same cycle as the timeout: the ack wins and fatal is not set.
- HOLD:
  - busy=1; in_error is ignored; the tracker is held at cons_cnt=0.
  - The hold counter decrements each cycle; at 0 → MON.
  - Error codes arriving in the cycle of re-entry to MON are tracked normally.
- resync_ack while in MON or HOLD: ignored.
- A mid-operation reset aborts any request immediately: resync_req goes to 0 asynchronously.
- Counter widths: the wait counter is clog2(TIMEOUT+1) bits; the hold counter is 8 bits.

Optional Feature:
- Macro: TMR_ERR_STATS_EN.
- When defined, adds these ports:
  - err_cnt_a, err_cnt_b, err_cnt_c: outputs, 16 bits each.
  - stats_clr: input, 1 bit, synchronous clear.
- Each counter increments on every in_valid sample whose in_error names that replica, in any state, including HOLD.
- Counters saturate at 16'hFFFF.
- stats_clr has priority over an increment in the same cycle.
- When the macro is not defined, these ports and counters do not exist and the core behaviour is unchanged.

Decomposition:
- Shared package/header holds:
  - error code constants ERR_NONE=0, ERR_A=1, ERR_B=2, ERR_C=3;
  - FSM state encodings MON=0, REQ=1, HOLD=2.
- One sub-module is natural: tmr_sat_counter (parameterised width, inc, clr, saturate). It is reused for the consecutive tracker and the optional stats counters.

Test Plan:
- Reset then 10 samples with in_error=0 and in_data=20'h12345 → out_data=20'h12345 one cycle later; resync_req stays 0 and busy stays 0.
- Four consecutive in_error=2 samples carrying 20'hABCDE → resync_req=1 one cycle after the 4th sample, resync_sel=2, resync_data=20'hABCDE; ack after 3 cycles → req drops, busy stays high for 8 further cycles.
- Pattern 2,2,2,3,2,2,2 → no request, because the run is broken by the switch to replica 3.
- Pattern 1,1,in_valid=0 gap,1,1 → request with resync_sel=1.
- No ack for 64 cycles → fatal=1, block back in MON; a second threshold run still issues a request while fatal stays 1.
- rst_n pulled low while resync_req=1 → all outputs 0 immediately. With TMR_ERR_STATS_EN: 5 ERR_C samples → err_cnt_c=5; stats_clr asserted together with a 6th ERR_C sample → err_cnt_c=0.
